// File: rtl/div_sched.sv
// Arbitrates two divide requesters onto one shared multi-cycle divider.
// Round-robin grant, divide-by-zero short-circuit, registered results.
module div_sched #(
  parameter int unsigned LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] y,
  output logic       err,
  output logic       busy,
  output logic       dv_ld,
  output logic [3:0] dv_a,
  output logic [3:0] dv_b,
  input  logic [3:0] dv_y
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       last;
  logic       ch;
  logic       gnt;
  logic [3:0] gnt_a;
  logic [3:0] gnt_b;

  // Round-robin pick: on a tie the channel not served last wins.
  always_comb begin
    gnt = req1;
    if (req0 && req1) gnt = ~last;
    gnt_a = gnt ? a1 : a0;
    gnt_b = gnt ? b1 : b0;
  end

  // Operand registers double as the divider operand outputs; cleared outside LOAD/WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      last  <= 1'b1;
      ch    <= 1'b0;
      y     <= 4'h0;
      err   <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= 1'b0;
      dv_ld <= 1'b0;
      dv_a  <= 4'h0;
      dv_b  <= 4'h0;
    end else begin
      dv_ld <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            ch   <= gnt;
            last <= gnt;
            busy <= 1'b1;
            if (gnt_b == 4'h0) begin
              y     <= 4'hF;
              err   <= 1'b1;
              done0 <= ~gnt;
              done1 <= gnt;
              state <= DONE;
            end else begin
              dv_a  <= gnt_a;
              dv_b  <= gnt_b;
              dv_ld <= 1'b1;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          cnt   <= 3'(LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            y     <= dv_y;
            err   <= 1'b0;
            dv_a  <= 4'h0;
            dv_b  <= 4'h0;
            done0 <= ~ch;
            done1 <= ch;
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed scenarios plus random traffic against a
// transaction-level timing/result model and a latency-accurate divider model.
module tb_div_sched;
  localparam int unsigned LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = 4'h0, b0 = 4'h0, a1 = 4'h0, b1 = 4'h0;
  logic       done0, done1, err, busy, dv_ld;
  logic [3:0] y, dv_a, dv_b, dv_y;

  int unsigned n_vec = 0, n_err = 0;

  div_sched #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .y(y), .err(err), .busy(busy),
    .dv_ld(dv_ld), .dv_a(dv_a), .dv_b(dv_b), .dv_y(dv_y)
  );

  always #5 clk = ~clk;

  // Shared divider: quotient valid only in the LAT-th cycle after the ld pulse.
  logic [3:0]  q_r = 4'h0;
  int unsigned k_r = 7;
  always @(posedge clk) begin
    if (dv_ld) begin
      q_r <= (dv_b != 4'h0) ? dv_a / dv_b : 4'h0;
      k_r <= 0;
    end else if (k_r < 7) begin
      k_r <= k_r + 1;
    end
  end
  assign dv_y = (k_r >= LAT - 1) ? q_r : ~q_r;

  // Transaction model: one operation record, timed from its grant edge.
  int unsigned cyc = 0, next_sample = 0, op_start = 0, op_done = 0;
  bit          have_op = 1'b0, op_zero = 1'b0, op_ch = 1'b0, last = 1'b1;
  logic [3:0]  op_a = 4'h0, op_b = 4'h0, op_y = 4'h0, ey = 4'h0;
  bit          eerr = 1'b0;
  bit          out0 = 1'b0, out1 = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      have_op     = 1'b0;
      last        = 1'b1;
      next_sample = cyc + 1;
      ey          = 4'h0;
      eerr        = 1'b0;
    end else begin
      if ((req0 || req1) && cyc >= next_sample) begin
        if (req0 && req1) op_ch = !last;
        else              op_ch = req1;
        last        = op_ch;
        op_a        = op_ch ? a1 : a0;
        op_b        = op_ch ? b1 : b0;
        op_zero     = (op_b == 4'h0);
        op_y        = op_zero ? 4'hF : op_a / op_b;
        op_start    = cyc;
        op_done     = op_zero ? cyc : cyc + LAT + 1;
        next_sample = op_zero ? cyc + 2 : cyc + LAT + 3;
        have_op     = 1'b1;
      end
      if (have_op && cyc == op_done) begin
        ey   = op_y;
        eerr = op_zero;
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit         norm, e_done0, e_done1, e_ld, e_busy, opnd;
    logic [3:0] ea, eb;
    @(negedge clk);
    norm    = have_op && !op_zero;
    e_done0 = have_op && cyc == op_done && !op_ch;
    e_done1 = have_op && cyc == op_done && op_ch;
    e_ld    = norm && cyc == op_start;
    e_busy  = have_op && cyc >= op_start && cyc <= op_done;
    opnd    = norm && cyc >= op_start && cyc < op_done;
    ea      = opnd ? op_a : 4'h0;
    eb      = opnd ? op_b : 4'h0;
    chk("done0", 8'(done0), 8'(e_done0));
    chk("done1", 8'(done1), 8'(e_done1));
    chk("busy",  8'(busy),  8'(e_busy));
    chk("dv_ld", 8'(dv_ld), 8'(e_ld));
    chk("dv_a",  8'(dv_a),  8'(ea));
    chk("dv_b",  8'(dv_b),  8'(eb));
    chk("y",     8'(y),     8'(ey));
    chk("err",   8'(err),   8'(eerr));
    if (e_done0) begin req0 = 1'b0; out0 = 1'b0; end
    if (e_done1) begin req1 = 1'b0; out1 = 1'b0; end
  endtask

  task automatic raise(input bit ch, input logic [3:0] a, input logic [3:0] b);
    if (!ch) begin req0 = 1'b1; a0 = a; b0 = b; out0 = 1'b1; end
    else     begin req1 = 1'b1; a1 = a; b1 = b; out1 = 1'b1; end
  endtask

  task automatic wait_idle(input string tag, input int unsigned maxc);
    int unsigned n = 0;
    while ((out0 || out1) && n < maxc) begin
      step();
      n++;
    end
    chk(tag, 8'(out0 || out1), 8'd0);
  endtask

  task automatic wait_in_wait0();
    int unsigned n = 0;
    while (!(have_op && !op_ch && cyc == op_start + 2) && n < 20) begin
      step();
      n++;
    end
    chk("reach_wait", 8'(n < 20), 8'd1);
  endtask

  function automatic logic [3:0] rnd_b();
    return ($urandom % 6 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    step();
    step();
    rst = 1'b0;

    raise(1'b0, 4'b1011, 4'b0010);
    wait_idle("single_ch0", 20);
    step();
    step();

    raise(1'b0, 4'd9, 4'd8);
    raise(1'b1, 4'd11, 4'd2);
    wait_idle("tie_pair", 40);

    raise(1'b0, 4'($urandom), 4'($urandom_range(1, 15)));
    raise(1'b1, 4'($urandom), 4'($urandom_range(1, 15)));
    for (int i = 0; i < int'(4 * (LAT + 3)); i++) begin
      step();
      if (!out0) raise(1'b0, 4'($urandom), 4'($urandom_range(1, 15)));
      if (!out1) raise(1'b1, 4'($urandom), 4'($urandom_range(1, 15)));
    end
    wait_idle("both_held", 40);

    raise(1'b1, 4'b0111, 4'h0);
    wait_idle("div_zero", 10);

    raise(1'b0, 4'd13, 4'd3);
    wait_in_wait0();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_idle("reset_abort", 20);

    raise(1'b0, 4'd14, 4'd3);
    wait_in_wait0();
    req0 = 1'b0;
    a0   = 4'd1;
    wait_idle("drop_in_wait", 20);

    for (int i = 0; i < 400; i++) begin
      step();
      if (!out0 && $urandom % 3 == 0) raise(1'b0, 4'($urandom), rnd_b());
      if (!out1 && $urandom % 3 == 0) raise(1'b1, 4'($urandom), rnd_b());
      if (req0 && have_op && !op_ch && !op_zero && cyc >= op_start && cyc < op_done
          && $urandom % 6 == 0) begin
        req0 = 1'b0;
        a0   = 4'($urandom);
        b0   = 4'($urandom);
      end
      if (req1 && have_op && op_ch && !op_zero && cyc >= op_start && cyc < op_done
          && $urandom % 6 == 0) begin
        req1 = 1'b0;
        a1   = 4'($urandom);
        b1   = 4'($urandom);
      end
    end
    wait_idle("random_drain", 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter: LAT, default 4, number of clk cycles the shared divider needs after its ld pulse before y is valid (range 1..7).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 divide request, held high until done0.
REQ-005 a0  input  4  requester 0 dividend.
REQ-006 b0  input  4  requester 0 divisor.
REQ-007 req1  input  1  requester 1 divide request, held high until done1.
REQ-008 a1  input  4  requester 1 dividend.
REQ-009 b1  input  4  requester 1 divisor.
REQ-010 done0  output  1  one-cycle pulse, result for requester 0 valid on y/err.
REQ-011 done1  output  1  one-cycle pulse, result for requester 1 valid on y/err.
REQ-012 y  output  4  registered quotient of the most recently completed operation.
REQ-013 err  output  1  registered divide-by-zero flag of the most recently completed operation.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 dv_ld  output  1  load strobe to the shared divider.
REQ-016 dv_a  output  4  dividend to the shared divider.
REQ-017 dv_b  output  4  divisor to the shared divider.
REQ-018 dv_y  input  4  quotient from the shared divider.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, WAIT, DONE; exactly one state active.
REQ-020 IDLE, no req: SHALL stay in IDLE.
REQ-021 IDLE, any req: SHALL grant one channel, latch its a/b into internal operand registers and its channel ID, and go to LOAD (or DONE if divisor is 0, see REQ-027).
REQ-022 Arbitration SHALL be round-robin: if both reqs are high, grant the channel not served last; after reset, channel 0 wins the first tie.
REQ-023 The last-served pointer SHALL update only on a grant, including divide-by-zero grants.
REQ-024 LOAD: dv_ld=1 for exactly one cycle; next state WAIT.
REQ-025 dv_a/dv_b SHALL drive the latched operands in LOAD and WAIT, and 0 in IDLE and DONE; dv_ld SHALL be 0 outside LOAD.
REQ-026 WAIT SHALL last exactly LAT cycles (3-bit down-counter); on the edge ending the last WAIT cycle, y<=dv_y, err<=0, next state DONE.
REQ-027 Divide-by-zero (latched divisor 4'b0000): the divider SHALL not be used; y<=4'hF, err<=1, IDLE -> DONE directly.
REQ-028 DONE: done of the granted channel =1 for exactly one cycle, the other done =0; next state IDLE.
REQ-029 Latency: done SHALL be high LAT+2 cycles after the sampling edge for a normal divide and 1 cycle after it for divide-by-zero; throughput is one operation per LAT+3 cycles.
REQ-030 req changes, or a/b changes after the grant, SHALL NOT affect an operation in progress; a dropped req SHALL still receive its done pulse.
REQ-031 A req arriving during LOAD/WAIT/DONE SHALL be held pending and arbitrated at the next IDLE; no request is lost while req stays high.
REQ-032 y and err SHALL hold their value until the next completion.

Reset
REQ-033 With rst=1 at a rising edge: state=IDLE, counter=0, last-served pointer=channel 1 (so channel 0 wins first), y=0, err=0.
REQ-034 During and after reset: done0=done1=busy=dv_ld=0, dv_a=dv_b=0.
REQ-035 rst asserted mid-operation SHALL abort it with no done pulse; a req held through reset is re-arbitrated from IDLE.

Verification
REQ-036 req0, a0=4'b1011, b0=4'b0010, dv_y model correct -> dv_ld pulse next cycle with dv_a=1011, dv_b=0010; done0 at LAT+2; y=4'b0101, err=0.
REQ-037 req0 and req1 raised on the same edge (9/8 and 11/2) after reset -> ch0 served first (y=0001), then ch1 (y=0101); done pulses LAT+3 cycles apart.
REQ-038 Both reqs held continuously for 4 operations -> grants alternate 0,1,0,1; no channel starved.
REQ-039 req1 with b1=0, a1=4'b0111 -> no dv_ld, done1 one cycle after the sampling edge, y=4'hF, err=1.
REQ-040 rst pulsed during WAIT -> no done pulse; outputs as in REQ-034; a held req0 is then re-served with the correct result.
REQ-041 req0 dropped and a0 changed during WAIT -> done0 still pulses; y equals the quotient of the originally latched operands.
